cfg_lut_bank: RTL and testbench

//  Bank of NUM_LUT independent K-input programmable look-up tables with a registered output.

---
 rtl/cfg_lut_bank.sv | 70 +++++++
 tb/tb_cfg_lut_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_lut_bank.sv
// cfg_lut_bank: bank of serially-programmed K-input LUTs with shadow/active tables and registered output
module cfg_lut_bank #(
  parameter int K       = 6,
  parameter int NUM_LUT = 4,
  parameter int CFG_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  output logic                 cfg_err,
  input  logic                 in_valid,
  input  logic [NUM_LUT*K-1:0] in_data,
  output logic                 out_valid,
  output logic [NUM_LUT-1:0]   out_data,
  output logic                 busy
);
  localparam int TBL    = 2**K;
  localparam int TOT    = NUM_LUT*TBL;
  localparam int NWORDS = TOT/CFG_W;
  localparam int CW     = NWORDS > 1 ? $clog2(NWORDS) : 1;
  typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [TOT-1:0]     shadow, active, merged;
  logic [TBL-1:0]     tbl [NUM_LUT];
  logic [NUM_LUT-1:0] lut_bit;
  logic               accept, last, eval;
  assign cfg_ready = state == LOAD;
  assign busy      = state == LOAD;
  // a restart request takes priority over a word offered in the same cycle
  assign accept    = cfg_valid && state == LOAD && !cfg_start;
  assign last      = accept && cnt == CW'(NWORDS-1);
  assign eval      = in_valid && state == RUN;
  always_comb begin
    merged = shadow;
    merged[cnt*CFG_W +: CFG_W] = cfg_data;
  end
  for (genvar g = 0; g < NUM_LUT; g++) begin : g_lut
    assign tbl[g]     = active[g*TBL +: TBL];
    assign lut_bit[g] = tbl[g][in_data[g*K +: K]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNCFG;
      cnt       <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      cfg_done  <= last;
      cfg_err   <= (cfg_valid && state != LOAD) || (cfg_start && state == LOAD);
      out_valid <= eval;
      if (eval) out_data <= lut_bit;
      if (cfg_start) cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
      if (accept) shadow <= merged;
      // the final word lands in the active table together with the rest of the shadow
      if (last) active <= merged;
      if (cfg_start) state <= LOAD;
      else if (last) state <= RUN;
    end
  end
endmodule

// File: tb/tb_cfg_lut_bank.sv
// tb_cfg_lut_bank: random-stimulus scoreboard bench for cfg_lut_bank against a table-level model
module tb_cfg_lut_bank;
  logic        clk = 0;
  logic        rst, cfg_start, cfg_valid, in_valid;
  logic [7:0]  cfg_data;
  logic [23:0] in_data;
  logic        cfg_ready, cfg_done, cfg_err, out_valid, busy;
  logic [3:0]  out_data;
  int          checks = 0, failures = 0, done_cnt = 0;
  logic [7:0]  words [32];
  logic        mdl [4][64];
  logic [3:0]  exp_q [$];
  bit          running = 0;

  cfg_lut_bank #(.K(6), .NUM_LUT(4), .CFG_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_eval(input logic [23:0] d);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = mdl[j][d[j*6 +: 6]];
    return r;
  endfunction

  task automatic commit_model;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 64; i++) mdl[j][i] = words[(j*64+i)/8][(j*64+i)%8];
  endtask

  task automatic clear_model;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 64; i++) mdl[j][i] = 1'b0;
  endtask

  task automatic eval(input logic [23:0] d);
    in_valid = 1;
    in_data  = d;
    if (running) exp_q.push_back(model_eval(d));
    tick;
    in_valid = 0;
  endtask

  task automatic start_cfg;
    cfg_start = 1;
    running   = 0;
    tick;
    cfg_start = 0;
    chk("ready_in_load", cfg_ready, 1);
    chk("busy_in_load", busy, 1);
  endtask

  task automatic send_words(input int from, input int to, input bit gaps);
    for (int w = from; w <= to; w++) begin
      if (gaps) repeat ($urandom_range(1, 3)) tick;
      cfg_valid = 1;
      cfg_data  = words[w];
      tick;
      cfg_valid = 0;
    end
  endtask

  task automatic finish_commit;
    chk("done_pulse", cfg_done, 1);
    chk("ready_after_commit", cfg_ready, 0);
    chk("busy_after_commit", busy, 0);
    commit_model();
    running = 1;
    tick;
    chk("done_single_cycle", cfg_done, 0);
  endtask

  task automatic load_all(input bit gaps);
    start_cfg();
    send_words(0, 30, gaps);
    chk("no_early_done", cfg_done, 0);
    send_words(31, 31, gaps);
    finish_commit();
  endtask

  task automatic set_test2_words;
    logic [7:0] par [8];
    par = '{8'h96, 8'h69, 8'h69, 8'h96, 8'h69, 8'h96, 8'h96, 8'h69};
    for (int w = 0; w < 32; w++)
      words[w] = w < 8 ? (w == 7 ? 8'h80 : 8'h00) : w < 16 ? 8'hFF : w < 24 ? par[w-16] : 8'h00;
  endtask

  task automatic random_evals(input int n);
    for (int i = 0; i < n; i++) eval(24'($urandom));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid got=%0h exp=none", out_data);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL out_data got=%0h exp=%0h", out_data, e);
          end
        end
      end
      if (cfg_done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1; cfg_start = 0; cfg_valid = 0; cfg_data = 0; in_valid = 0; in_data = 0;
    clear_model();
    repeat (3) tick;
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    for (int i = 0; i < 5; i++) begin
      eval(24'($urandom));
      chk("uncfg_out_valid", out_valid, 0);
      chk("uncfg_out_data", out_data, 0);
      chk("uncfg_ready", cfg_ready, 0);
      chk("uncfg_busy", busy, 0);
    end

    set_test2_words();
    d0 = done_cnt;
    load_all(0);
    chk("done_count_plain", done_cnt - d0, 1);
    eval(24'hFC01FF);
    tick;
    random_evals(40);

    d0 = done_cnt;
    load_all(1);
    tick;
    chk("done_count_gaps", done_cnt - d0, 1);
    eval(24'hFC01FF);
    random_evals(40);

    in_valid  = 1;
    in_data   = 24'($urandom);
    exp_q.push_back(model_eval(in_data));
    cfg_start = 1;
    running   = 0;
    tick;
    cfg_start = 0;
    in_valid  = 0;
    chk("start_eval_out_valid", out_valid, 1);
    chk("start_eval_ready", cfg_ready, 1);
    for (int w = 0; w < 32; w++) words[w] = 8'($urandom);
    send_words(0, 9, 0);
    rst = 1;
    tick;
    rst = 0;
    clear_model();
    exp_q.delete();
    chk("midload_rst_ready", cfg_ready, 0);
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_out_valid", out_valid, 0);
    chk("midload_rst_out_data", out_data, 0);
    chk("midload_rst_done", cfg_done, 0);
    tick;
    chk("midload_rst_no_done", cfg_done, 0);
    for (int w = 0; w < 32; w++) words[w] = 8'h00;
    load_all(0);
    random_evals(20);

    for (int w = 0; w < 32; w++) words[w] = 8'($urandom);
    start_cfg();
    send_words(0, 4, 0);
    cfg_start = 1;
    tick;
    cfg_start = 0;
    chk("restart_err", cfg_err, 1);
    chk("restart_busy", busy, 1);
    eval(24'($urandom));
    chk("restart_err_once", cfg_err, 0);
    chk("load_ignores_in", out_valid, 0);
    for (int w = 0; w < 32; w++) words[w] = 8'($urandom);
    send_words(0, 30, 0);
    chk("restart_no_early_done", cfg_done, 0);
    chk("restart_still_busy", busy, 1);
    send_words(31, 31, 0);
    finish_commit();
    random_evals(60);

    set_test2_words();
    load_all(0);
    cfg_valid = 1;
    cfg_data  = 8'hFF;
    tick;
    cfg_valid = 0;
    chk("run_cfg_valid_err", cfg_err, 1);
    chk("run_cfg_valid_ready", cfg_ready, 0);
    eval(24'hFC01FF);
    chk("run_err_once", cfg_err, 0);
    random_evals(30);
    tick;
    tick;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
